// File: rtl/mesm6_ifetch.sv
// Instruction prefetch unit for the mesm6 core: fetches 48-bit words into a small queue
// and hands out 24-bit half-word opcodes, with flush/restart on redirect.
module mesm6_ifetch #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ibus_fetch,
  output logic [14:0] ibus_addr,
  input  logic [47:0] ibus_input,
  input  logic        ibus_done,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        op_valid,
  input  logic        op_ready,
  output logic [23:0] opcode,
  output logic [15:0] op_pc
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DepthC = CW'(DEPTH);

  typedef enum logic [1:0] {StIdle, StFetch, StDrain} state_e;

  state_e        state_q, state_d;
  logic [47:0]   word_mem [DEPTH];
  logic [14:0]   addr_mem [DEPTH];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q, count_d, free;
  logic [14:0]   fa_q, fa_d, drain_addr_q;
  logic          hp_q, hp_d;
  logic          consume, pop, push;

  assign consume = op_valid & op_ready & ~redirect;
  assign pop     = consume & hp_q;
  assign push    = (state_q == StFetch) & ibus_done & ~redirect;
  // Free slots including a pop happening this cycle.
  assign free    = DepthC - count_q + {{PW{1'b0}}, pop};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (!redirect && (free != '0)) state_d = StFetch;
      end
      StFetch: begin
        if (redirect) begin
          state_d = ibus_done ? StFetch : StDrain;
        end else if (ibus_done && (free <= CW'(1))) begin
          state_d = StIdle;
        end
      end
      StDrain: begin
        if (ibus_done) state_d = StFetch;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ibus_fetch = (state_q != StIdle);
    // While draining, the bus keeps the stale address even though fa already moved on.
    ibus_addr  = (state_q == StDrain) ? drain_addr_q : fa_q;
    op_valid   = (count_q != '0);
    opcode     = hp_q ? word_mem[rd_ptr_q][23:0] : word_mem[rd_ptr_q][47:24];
    op_pc      = {addr_mem[rd_ptr_q], hp_q};
  end

  always_comb begin
    fa_d    = fa_q;
    hp_d    = hp_q;
    count_d = count_q;
    if (redirect) begin
      fa_d    = redirect_pc[15:1];
      hp_d    = redirect_pc[0];
      count_d = '0;
    end else begin
      if (push) fa_d = fa_q + 15'd1;
      if (consume) hp_d = ~hp_q;
      count_d = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q      <= '0;
      fa_q         <= RESET_PC[15:1];
      hp_q         <= RESET_PC[0];
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      drain_addr_q <= '0;
    end else begin
      count_q <= count_d;
      fa_q    <= fa_d;
      hp_q    <= hp_d;
      if (state_q == StFetch && redirect && !ibus_done) drain_addr_q <= fa_q;
      if (redirect) begin
        rd_ptr_q <= wr_ptr_q;
      end else begin
        if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
        if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      word_mem[wr_ptr_q] <= ibus_input;
      addr_mem[wr_ptr_q] <= fa_q;
    end
  end

endmodule
